// File: rtl/cic_interpolator_if.sv
// Sample-stream bundle for the CIC interpolator: low-rate ready/valid input side
// plus the high-rate output, valid flag and underrun pulse.
interface cic_interpolator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 22
);
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [OUT_WIDTH-1:0]  data_out;
  logic                         out_valid;
  logic                         underrun;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  data_out,
    input  out_valid,
    input  underrun
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output data_out,
    output out_valid,
    output underrun
  );
endinterface

// File: rtl/cic_interpolator.sv
// Multistage CIC interpolator: low-rate combs feed a zero-stuffing upsampler and
// high-rate integrators, all in wrapping two's complement at the full growth width.
module cic_interpolator #(
  parameter int DATA_WIDTH    = 16,
  parameter int INTERP_FACTOR = 4,
  parameter int NUM_STAGES    = 3,
  parameter int DIFF_DELAY    = 1
) (
  input  logic              clk,
  input  logic              reset,
  cic_interpolator_if.slave bus_io
);

  localparam int OUT_WIDTH = DATA_WIDTH + NUM_STAGES * $clog2(INTERP_FACTOR * DIFF_DELAY);
  localparam int PW        = $clog2(INTERP_FACTOR);
  localparam int FW        = $clog2(NUM_STAGES + 1);

  localparam logic [PW-1:0] PHASE_LAST = PW'(INTERP_FACTOR - 1);
  localparam logic [FW-1:0] FILL_DONE  = FW'(NUM_STAGES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          underrun_q, underrun_d;

  logic signed [OUT_WIDTH-1:0] dly_q   [NUM_STAGES][DIFF_DELAY];
  logic signed [OUT_WIDTH-1:0] combIn  [NUM_STAGES];
  logic signed [OUT_WIDTH-1:0] combAcc;
  logic signed [OUT_WIDTH-1:0] comb_q, comb_d;
  logic signed [OUT_WIDTH-1:0] integ_q [NUM_STAGES];
  logic signed [OUT_WIDTH-1:0] integ_d [NUM_STAGES];

  logic                        running;
  logic                        atLastPhase;
  logic                        ready;
  logic                        slotEdge;
  logic                        captureEdge;
  logic signed [OUT_WIDTH-1:0] sample;
  logic signed [OUT_WIDTH-1:0] upsampled;

  assign running     = (state_q == RUN);
  assign atLastPhase = (phase_q == PHASE_LAST);
  assign ready       = !running || atLastPhase;
  assign slotEdge    = running && atLastPhase;
  assign captureEdge = running ? slotEdge : bus_io.in_valid;

  // A slot with no valid sample still advances the combs, using zero as the input.
  assign sample    = bus_io.in_valid ? OUT_WIDTH'(bus_io.in_data) : '0;
  assign upsampled = (running && phase_q == '0) ? comb_q : '0;

  always_comb begin
    combAcc = sample;
    for (int k = 0; k < NUM_STAGES; k++) begin
      combIn[k] = combAcc;
      combAcc   = combAcc - dly_q[k][DIFF_DELAY-1];
    end
    comb_d = combAcc;
  end

  always_comb begin
    integ_d[0] = integ_q[0] + upsampled;
    for (int k = 1; k < NUM_STAGES; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    fill_d     = fill_q;
    underrun_d = slotEdge && !bus_io.in_valid;
    if (!running && bus_io.in_valid) begin
      state_d = RUN;
    end
    if (captureEdge) begin
      phase_d = '0;
    end else if (running) begin
      phase_d = phase_q + 1'b1;
    end
    if (running && fill_q != FILL_DONE) begin
      fill_d = fill_q + 1'b1;
    end
  end

  // Combs and their delay lines move only on capture edges; integrators every RUN edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      fill_q     <= '0;
      underrun_q <= 1'b0;
      comb_q     <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        integ_q[k] <= '0;
        for (int m = 0; m < DIFF_DELAY; m++) begin
          dly_q[k][m] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      fill_q     <= fill_d;
      underrun_q <= underrun_d;
      if (captureEdge) begin
        comb_q <= comb_d;
        for (int k = 0; k < NUM_STAGES; k++) begin
          dly_q[k][0] <= combIn[k];
          for (int m = 1; m < DIFF_DELAY; m++) begin
            dly_q[k][m] <= dly_q[k][m-1];
          end
        end
      end
      if (running) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          integ_q[k] <= integ_d[k];
        end
      end
    end
  end

  assign bus_io.in_ready  = ready;
  assign bus_io.data_out  = integ_q[NUM_STAGES-1];
  assign bus_io.out_valid = (fill_q == FILL_DONE);
  assign bus_io.underrun  = underrun_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: an N=2 and an N=3 instance share stimulus and are checked
// every cycle against a direct convolution with the N-fold boxcar impulse response.
module tb_cic_interpolator;

  localparam int DW = 16;
  localparam int R  = 4;
  localparam int M  = 1;
  localparam int NA = 2;
  localparam int NB = 3;
  localparam int WA = DW + NA * $clog2(R * M);
  localparam int WB = DW + NB * $clog2(R * M);
  localparam int HLEN = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cic_interpolator_if #(.DATA_WIDTH(DW), .OUT_WIDTH(WA)) busA ();
  cic_interpolator_if #(.DATA_WIDTH(DW), .OUT_WIDTH(WB)) busB ();

  cic_interpolator #(
    .DATA_WIDTH(DW), .INTERP_FACTOR(R), .NUM_STAGES(NA), .DIFF_DELAY(M)
  ) dutA (
    .clk(clk), .reset(reset), .bus_io(busA)
  );

  cic_interpolator #(
    .DATA_WIDTH(DW), .INTERP_FACTOR(R), .NUM_STAGES(NB), .DIFF_DELAY(M)
  ) dutB (
    .clk(clk), .reset(reset), .bus_io(busB)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: edge count since the first accept, plus every sample the filter took.
  bit     mRun;
  int     mEdge;
  bit     mUnder;
  longint xs[$];
  longint hTab[4][HLEN];

  task automatic buildTables();
    longint acc;
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < HLEN; n++) hTab[s][n] = 0;
    end
    hTab[0][0] = 1;
    for (int s = 1; s < 4; s++) begin
      for (int n = 0; n < HLEN; n++) begin
        acc = 0;
        for (int j = 0; j < R * M; j++) begin
          if (n - j >= 0) acc += hTab[s-1][n-j];
        end
        hTab[s][n] = acc;
      end
    end
  endtask

  function automatic void modelClear();
    mRun   = 1'b0;
    mEdge  = 0;
    mUnder = 1'b0;
    xs.delete();
  endfunction

  function automatic longint expOut(input int nst);
    longint acc;
    int     t;
    int     idx;
    acc = 0;
    if (!mRun || mEdge < nst) return 0;
    t = mEdge - nst;
    foreach (xs[k]) begin
      idx = t - k * R;
      if (idx >= 0 && idx < HLEN) acc += xs[k] * hTab[nst][idx];
    end
    return acc;
  endfunction

  function automatic bit expReady();
    return !mRun || ((mEdge % R) == R - 1);
  endfunction

  function automatic bit expValid(input int nst);
    return mRun && (mEdge >= nst);
  endfunction

  task automatic drive(input logic v, input longint d);
    busA.in_valid = v;
    busA.in_data  = DW'(d);
    busB.in_valid = v;
    busB.in_data  = DW'(d);
  endtask

  task automatic clockEdge();
    logic   v;
    longint d;
    v = busA.in_valid;
    d = longint'(busA.in_data);
    @(posedge clk);
    if (reset) begin
      modelClear();
    end else if (!mRun) begin
      mUnder = 1'b0;
      if (v) begin
        mRun  = 1'b1;
        mEdge = 0;
        xs.push_back(d);
      end
    end else begin
      mEdge++;
      mUnder = 1'b0;
      if (mEdge % R == 0) begin
        xs.push_back(v ? d : 0);
        mUnder = !v;
      end
    end
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    drive(1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelClear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 7);
    #2;
    tests++;
    if (busA.in_ready !== 1'b1 || busB.in_ready !== 1'b1 || busA.data_out !== '0 || busB.data_out !== '0) begin
      fails++;
      $display("[TB] FAIL reset_values: ready A=%b B=%b data A=%0d B=%0d, expected ready 1 data 0",
               busA.in_ready, busB.in_ready, busA.data_out, busB.data_out);
    end
    tests++;
    if (busA.out_valid !== 1'b0 || busB.out_valid !== 1'b0 || busA.underrun !== 1'b0 || busB.underrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: out_valid A=%b B=%b underrun A=%b B=%b, expected all 0",
               busA.out_valid, busB.out_valid, busA.underrun, busB.underrun);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelClear();
    drive(1'b0, 0);
    for (int c = 0; c < 6; c++) begin
      clockEdge();
      tests++;
      if (busA.in_ready !== 1'b1 || busA.out_valid !== 1'b0 || busB.out_valid !== 1'b0 ||
          busA.data_out !== '0 || busB.data_out !== '0) begin
        fails++;
        $display("[TB] FAIL reset_accept_collision cyc %0d: ready=%b valid A=%b B=%b data A=%0d B=%0d, expected idle zeros",
                 c, busA.in_ready, busA.out_valid, busB.out_valid, busA.data_out, busB.data_out);
      end
    end
  endtask

  task automatic test_impulse(input bit doReset);
    int impTbl[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    logic signed [WA-1:0] want;
    if (doReset) applyReset();
    for (int c = 0; c < 24; c++) begin
      drive(1'b1, (xs.size() == 0) ? 1 : 0);
      tests++;
      if (busA.in_ready !== expReady() || busB.in_ready !== expReady()) begin
        fails++;
        $display("[TB] FAIL impulse_ready cyc %0d: A=%b B=%b, expected %b", c, busA.in_ready, busB.in_ready, expReady());
      end
      clockEdge();
      tests++;
      if (busA.data_out !== WA'(expOut(NA)) || busB.data_out !== WB'(expOut(NB))) begin
        fails++;
        $display("[TB] FAIL impulse_data cyc %0d: A=%0d B=%0d, expected A=%0d B=%0d",
                 c, busA.data_out, busB.data_out, WA'(expOut(NA)), WB'(expOut(NB)));
      end
      tests++;
      if (busA.out_valid !== expValid(NA) || busB.out_valid !== expValid(NB) ||
          busA.underrun !== mUnder || busB.underrun !== mUnder) begin
        fails++;
        $display("[TB] FAIL impulse_flags cyc %0d: valid A=%b B=%b underrun A=%b B=%b, expected valid %b/%b underrun %b",
                 c, busA.out_valid, busB.out_valid, busA.underrun, busB.underrun, expValid(NA), expValid(NB), mUnder);
      end
      if (mRun && mEdge >= NA) begin
        want = (mEdge - NA < 8) ? WA'(impTbl[mEdge-NA]) : '0;
        tests++;
        if (busA.data_out !== want) begin
          fails++;
          $display("[TB] FAIL impulse_table e%0d: got %0d, expected %0d", mEdge, busA.data_out, want);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    applyReset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, (xs.size() == 0) ? 1 : 0);
      clockEdge();
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (busA.data_out !== '0 || busB.data_out !== '0 || busA.out_valid !== 1'b0 || busB.out_valid !== 1'b0 ||
        busA.in_ready !== 1'b1 || busB.in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midrun_reset: data A=%0d B=%0d valid A=%b B=%b ready A=%b B=%b, expected 0 0 0 0 1 1",
               busA.data_out, busB.data_out, busA.out_valid, busB.out_valid, busA.in_ready, busB.in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelClear();
    test_impulse(1'b0);
  endtask

  task automatic test_dc(input longint value, input string name);
    longint gainA;
    longint gainB;
    gainA = ((R * M) ** NA) / R;
    gainB = ((R * M) ** NB) / R;
    applyReset();
    for (int c = 0; c < 44; c++) begin
      drive(1'b1, value);
      tests++;
      if (busA.in_ready !== expReady() || busB.in_ready !== expReady()) begin
        fails++;
        $display("[TB] FAIL %s_ready cyc %0d: A=%b B=%b, expected %b", name, c, busA.in_ready, busB.in_ready, expReady());
      end
      clockEdge();
      tests++;
      if (busA.data_out !== WA'(expOut(NA)) || busB.data_out !== WB'(expOut(NB))) begin
        fails++;
        $display("[TB] FAIL %s_data cyc %0d: A=%0d B=%0d, expected A=%0d B=%0d",
                 name, c, busA.data_out, busB.data_out, WA'(expOut(NA)), WB'(expOut(NB)));
      end
      if (c >= 36) begin
        tests++;
        if (busA.data_out !== WA'(value * gainA) || busB.data_out !== WB'(value * gainB)) begin
          fails++;
          $display("[TB] FAIL %s_settled cyc %0d: A=%0d B=%0d, expected A=%0d B=%0d",
                   name, c, busA.data_out, busB.data_out, value * gainA, value * gainB);
        end
      end
    end
  endtask

  task automatic test_underrun();
    bit   dropped;
    logic v;
    int   pulsesA;
    int   pulsesB;
    dropped = 1'b0;
    pulsesA = 0;
    pulsesB = 0;
    applyReset();
    for (int c = 0; c < 48; c++) begin
      v = !(mRun && expReady() && !dropped && xs.size() >= 6);
      if (!v) dropped = 1'b1;
      drive(v, 1);
      tests++;
      if (busA.in_ready !== expReady() || busB.in_ready !== expReady()) begin
        fails++;
        $display("[TB] FAIL underrun_ready cyc %0d: A=%b B=%b, expected %b", c, busA.in_ready, busB.in_ready, expReady());
      end
      clockEdge();
      if (busA.underrun === 1'b1) pulsesA++;
      if (busB.underrun === 1'b1) pulsesB++;
      tests++;
      if (busA.underrun !== mUnder || busB.underrun !== mUnder) begin
        fails++;
        $display("[TB] FAIL underrun_flag cyc %0d: A=%b B=%b, expected %b", c, busA.underrun, busB.underrun, mUnder);
      end
      tests++;
      if (busA.data_out !== WA'(expOut(NA)) || busB.data_out !== WB'(expOut(NB))) begin
        fails++;
        $display("[TB] FAIL underrun_data cyc %0d: A=%0d B=%0d, expected A=%0d B=%0d",
                 c, busA.data_out, busB.data_out, WA'(expOut(NA)), WB'(expOut(NB)));
      end
    end
    tests++;
    if (pulsesA != 1 || pulsesB != 1) begin
      fails++;
      $display("[TB] FAIL underrun_pulse_count: A=%0d B=%0d, expected 1", pulsesA, pulsesB);
    end
  endtask

  task automatic test_back_to_back();
    longint base;
    longint nextVal;
    longint consumed[$];
    logic   tookIt;
    int     readyCount;
    base       = longint'($urandom_range(0, 1000));
    nextVal    = base;
    readyCount = 0;
    applyReset();
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, nextVal);
      tests++;
      if (busA.in_ready !== expReady() || busB.in_ready !== expReady()) begin
        fails++;
        $display("[TB] FAIL pacing_ready cyc %0d: A=%b B=%b, expected %b", c, busA.in_ready, busB.in_ready, expReady());
      end
      tookIt = busA.in_ready;
      if (tookIt === 1'b1) readyCount++;
      clockEdge();
      if (tookIt === 1'b1) begin
        consumed.push_back(nextVal);
        nextVal++;
      end
      tests++;
      if (busA.data_out !== WA'(expOut(NA)) || busB.data_out !== WB'(expOut(NB))) begin
        fails++;
        $display("[TB] FAIL pacing_data cyc %0d: A=%0d B=%0d, expected A=%0d B=%0d",
                 c, busA.data_out, busB.data_out, WA'(expOut(NA)), WB'(expOut(NB)));
      end
    end
    tests++;
    if (readyCount != 10) begin
      fails++;
      $display("[TB] FAIL pacing_ready_count: got %0d, expected 10", readyCount);
    end
    tests++;
    if (xs.size() != 10) begin
      fails++;
      $display("[TB] FAIL pacing_accept_count: model took %0d, expected 10", xs.size());
    end
    foreach (consumed[i]) begin
      tests++;
      if (consumed[i] != base + i) begin
        fails++;
        $display("[TB] FAIL pacing_sequence idx %0d: got %0d, expected %0d", i, consumed[i], base + i);
      end
    end
  endtask

  task automatic test_random();
    logic   v;
    longint d;
    applyReset();
    for (int c = 0; c < 80; c++) begin
      v = ($urandom_range(0, 9) != 0);
      d = longint'($urandom_range(0, 65535)) - 32768;
      drive(v, d);
      tests++;
      if (busA.in_ready !== expReady() || busB.in_ready !== expReady()) begin
        fails++;
        $display("[TB] FAIL random_ready cyc %0d: A=%b B=%b, expected %b", c, busA.in_ready, busB.in_ready, expReady());
      end
      clockEdge();
      tests++;
      if (busA.data_out !== WA'(expOut(NA)) || busB.data_out !== WB'(expOut(NB))) begin
        fails++;
        $display("[TB] FAIL random_data cyc %0d: A=%0d B=%0d, expected A=%0d B=%0d",
                 c, busA.data_out, busB.data_out, WA'(expOut(NA)), WB'(expOut(NB)));
      end
      tests++;
      if (busA.out_valid !== expValid(NA) || busB.out_valid !== expValid(NB) ||
          busA.underrun !== mUnder || busB.underrun !== mUnder) begin
        fails++;
        $display("[TB] FAIL random_flags cyc %0d: valid A=%b B=%b underrun A=%b B=%b, expected %b/%b %b",
                 c, busA.out_valid, busB.out_valid, busA.underrun, busB.underrun, expValid(NA), expValid(NB), mUnder);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 0);
    modelClear();
    buildTables();
    test_reset();
    test_impulse(1'b1);
    test_reset_midrun();
    test_dc(1, "dc_one");
    test_dc(-32768, "dc_negfs");
    test_underrun();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
